i2s_capture: RTL

I2S_CAPTURE -- requirements
Module: i2s_capture

---
 rtl/i2s_capture_pkg.sv | 14 +
 rtl/i2s_capture_sync_edge.sv | 35 +++
 rtl/i2s_capture.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_capture_pkg.sv
// Shared audio types for the I2S capture path.
// State encoding and default word geometry.
package i2s_capture_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/i2s_capture_sync_edge.sv
// Synchronizer chain plus one edge-detect register.
// Level, rise and fall are all aligned to the same clk cycle.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  // shift the async input through the chain, then remember last level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      last <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~last;
  assign fall  = ~level & last;

endmodule

// File: rtl/i2s_capture.sv
// Philips I2S receiver: one channel word per ws phase,
// MSB first, handed out on a valid/ready register.
module i2s_capture
  import i2s_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  ws,
  input  logic                  sd,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_chan,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  clr_err,
  output logic                  locked,
  output logic                  ovf,
  output logic                  frm_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DATA_WIDTH);

  logic sclk_rise;
  logic ws_lvl;
  logic sd_lvl;
  logic unused_sclk_lvl;
  logic unused_sclk_fall;
  logic unused_ws_rise;
  logic unused_ws_fall;
  logic unused_sd_rise;
  logic unused_sd_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sclk),
    .level   (unused_sclk_lvl),
    .rise    (sclk_rise),
    .fall    (unused_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ws (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ws),
    .level   (ws_lvl),
    .rise    (unused_ws_rise),
    .fall    (unused_ws_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sd (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sd),
    .level   (sd_lvl),
    .rise    (unused_sd_rise),
    .fall    (unused_sd_fall)
  );

  cap_state_t            state_q;
  cap_state_t            state_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_WIDTH-2:0] shreg_q;
  logic [DATA_WIDTH-2:0] shreg_d;
  logic                  chan_q;
  logic                  chan_d;
  logic                  ws_prev;
  logic                  ws_seen;
  logic                  ws_edge;
  logic                  done;
  logic                  frm_set;
  logic                  ovf_set;
  logic                  load;
  logic [DATA_WIDTH-1:0] word;

  // the first rise after reset/enable only records ws
  assign ws_edge = ws_seen & (ws_lvl ^ ws_prev);
  assign word    = {shreg_q, sd_lvl};
  assign load    = done & (~m_valid | m_ready);
  assign ovf_set = done & m_valid & ~m_ready;

  // ws level seen at the previous bit-clock rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_prev <= 1'b0;
      ws_seen <= 1'b0;
    end else if (!enable) begin
      ws_seen <= 1'b0;
    end else if (sclk_rise) begin
      ws_prev <= ws_lvl;
      ws_seen <= 1'b1;
    end
  end

  // framing state, bit counter, partial word and channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEEK;
      cnt_q   <= '0;
      shreg_q <= '0;
      chan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      chan_q  <= chan_d;
    end
  end

  // next state; the rise that shows a ws change still carries
  // the last bit of the word that is ending
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    chan_d  = chan_q;
    done    = 1'b0;
    frm_set = 1'b0;
    if (!enable) begin
      state_d = SEEK;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (sclk_rise) begin
      unique case (state_q)
        SEEK: begin
          if (ws_edge) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
            chan_d  = ws_lvl;
          end
        end
        SHIFT: begin
          done = (cnt_q == LAST_BIT);
          if (ws_edge) begin
            frm_set = ~done;
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
            chan_d  = ws_lvl;
          end else if (done) begin
            state_d = PAD;
            cnt_d   = FULL;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = word[DATA_WIDTH-2:0];
          end
        end
        PAD: begin
          if (ws_edge) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
            chan_d  = ws_lvl;
          end
        end
        default: begin
          state_d = SEEK;
          cnt_d   = '0;
          shreg_d = '0;
        end
      endcase
    end
  end

  // output register: load on free slot, drop on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= '0;
      m_chan  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!enable) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= word;
      m_chan  <= chan_q;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // sticky error flags; a new event beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
      if (frm_set) begin
        frm_err <= 1'b1;
      end else if (clr_err) begin
        frm_err <= 1'b0;
      end
    end
  end

  assign locked = (state_q == SHIFT) || (state_q == PAD);

endmodule
